adder_xbit_pipe: RTL and testbench

//   Pipelined, parametrised carry-lookahead adder/subtractor with valid/ready handshakes on input and output.

---
 rtl/adder_xbit_pipe_if.sv | 27 ++
 rtl/adder_xbit_pipe.sv | 146 ++++++++++++++
 tb/tb_adder_xbit_pipe.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/adder_xbit_pipe_if.sv
// Handshake bundle for the pipelined adder: operation request in, result out.
// The master side issues operations and accepts results; the adder is the slave.
interface adder_xbit_pipe_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  i_valid;
   logic                  o_ready;
   logic [DATA_WIDTH-1:0] i_num_a;
   logic [DATA_WIDTH-1:0] i_num_b;
   logic                  i_cry;
   logic                  i_sub;
   logic                  o_valid;
   logic                  i_ready;
   logic [DATA_WIDTH-1:0] o_res;
   logic                  o_cry;
   logic                  o_ovf;

   modport master (
      output i_valid, i_num_a, i_num_b, i_cry, i_sub, i_ready,
      input  o_ready, o_valid, o_res, o_cry, o_ovf
   );

   modport slave (
      input  i_valid, i_num_a, i_num_b, i_cry, i_sub, i_ready,
      output o_ready, o_valid, o_res, o_cry, o_ovf
   );
endinterface

// File: rtl/adder_xbit_pipe.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves one CHUNK-bit slice
// with lookahead carry and hands the carry to the next stage; valid/ready on both ends.

module adder_xbit_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int CHUNK      = 8,
   parameter int K          = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  ld,
   input  logic                  v_d,
   input  logic [DATA_WIDTH-1:0] w_d,
   input  logic [DATA_WIDTH-1:0] b_d,
   input  logic                  c_d,
   output logic                  v_q,
   output logic [DATA_WIDTH-1:0] w_q,
   output logic [DATA_WIDTH-1:0] b_q,
   output logic                  c_q,
   output logic                  ovf_q
);
   localparam int LO = K * CHUNK;

   logic [CHUNK-1:0]      g, p, s;
   logic [CHUNK:0]        c;
   logic [DATA_WIDTH-1:0] w_nx;

   assign g = w_d[LO +: CHUNK] & b_d[LO +: CHUNK];
   assign p = w_d[LO +: CHUNK] ^ b_d[LO +: CHUNK];

   // Flat lookahead: every carry is a sum of generate terms gated by the propagates above them.
   always_comb begin
      logic cc, pp;
      cc   = 1'b0;
      pp   = 1'b1;
      c    = '0;
      c[0] = c_d;
      for (int i = 0; i < CHUNK; i++) begin
         cc = 1'b0;
         for (int j = 0; j <= i; j++) begin
            pp = 1'b1;
            for (int m = j + 1; m <= i; m++) pp = pp & p[m];
            cc = cc | (g[j] & pp);
         end
         pp = 1'b1;
         for (int m = 0; m <= i; m++) pp = pp & p[m];
         c[i+1] = cc | (pp & c_d);
      end
   end

   assign s = p ^ c[CHUNK-1:0];

   // w carries finished result chunks below LO and untouched operand a above.
   always_comb begin
      w_nx              = w_d;
      w_nx[LO +: CHUNK] = s;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v_q   <= 1'b0;
         w_q   <= '0;
         b_q   <= '0;
         c_q   <= 1'b0;
         ovf_q <= 1'b0;
      end else if (ld) begin
         v_q <= v_d;
         if (v_d) begin
            w_q   <= w_nx;
            b_q   <= b_d;
            c_q   <= c[CHUNK];
            ovf_q <= c[CHUNK] ^ c[CHUNK-1];
         end
      end
   end
endmodule

module adder_xbit_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int STAGE_NUM  = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   adder_xbit_pipe_if.slave   bus
);
   localparam int CHUNK = DATA_WIDTH / STAGE_NUM;

   logic [STAGE_NUM-1:0]                 vld_pipe;
   logic [STAGE_NUM-1:0]                 ld;
   logic [STAGE_NUM-1:0][DATA_WIDTH-1:0] w_q;
   logic [STAGE_NUM-1:0][DATA_WIDTH-1:0] b_q;
   logic [STAGE_NUM-1:0]                 c_q;
   logic [STAGE_NUM-1:0]                 ovf_q;
   logic                                 unused_ok;

   // A stage may load when empty or when everything downstream of it moves; bubbles collapse.
   always_comb begin
      ld              = '0;
      ld[STAGE_NUM-1] = ~vld_pipe[STAGE_NUM-1] | bus.i_ready;
      for (int k = STAGE_NUM - 2; k >= 0; k--) ld[k] = ~vld_pipe[k] | ld[k+1];
   end

   assign bus.o_ready = ld[0];

   for (genvar k = 0; k < STAGE_NUM; k++) begin : g_stg
      logic                  v_d, c_d;
      logic [DATA_WIDTH-1:0] w_d, b_d;
      if (k == 0) begin : g_head
         assign v_d = bus.i_valid;
         assign w_d = bus.i_num_a;
         assign b_d = bus.i_sub ? ~bus.i_num_b : bus.i_num_b;
         assign c_d = bus.i_cry ^ bus.i_sub;
      end else begin : g_body
         assign v_d = vld_pipe[k-1];
         assign w_d = w_q[k-1];
         assign b_d = b_q[k-1];
         assign c_d = c_q[k-1];
      end
      adder_xbit_stage #(
         .DATA_WIDTH (DATA_WIDTH),
         .CHUNK      (CHUNK),
         .K          (k)
      ) u_stage (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .ld    (ld[k]),
         .v_d   (v_d),
         .w_d   (w_d),
         .b_d   (b_d),
         .c_d   (c_d),
         .v_q   (vld_pipe[k]),
         .w_q   (w_q[k]),
         .b_q   (b_q[k]),
         .c_q   (c_q[k]),
         .ovf_q (ovf_q[k])
      );
   end

   // Last operand copy and early-stage overflow flags have no consumer.
   assign unused_ok = ^{b_q[STAGE_NUM-1], ovf_q};

   assign bus.o_valid = vld_pipe[STAGE_NUM-1];
   assign bus.o_res   = w_q[STAGE_NUM-1];
   assign bus.o_cry   = c_q[STAGE_NUM-1];
   assign bus.o_ovf   = ovf_q[STAGE_NUM-1];
endmodule

// File: tb/tb_adder_xbit_pipe.sv
// Directed bench for adder_xbit_pipe: 32/4 vectors, stall/ordering, mid-flight reset,
// plus randomized 8/1 and 8/8 instances checked against a scoreboard.
module tb_adder_xbit_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   adder_xbit_pipe_if #(.DATA_WIDTH(32)) b32 ();
   adder_xbit_pipe_if #(.DATA_WIDTH(8))  b8a ();
   adder_xbit_pipe_if #(.DATA_WIDTH(8))  b8b ();

   adder_xbit_pipe #(.DATA_WIDTH(32), .STAGE_NUM(4)) u32 (.i_clk(clk), .i_rst(rst), .bus(b32));
   adder_xbit_pipe #(.DATA_WIDTH(8),  .STAGE_NUM(1)) u8a (.i_clk(clk), .i_rst(rst), .bus(b8a));
   adder_xbit_pipe #(.DATA_WIDTH(8),  .STAGE_NUM(8)) u8b (.i_clk(clk), .i_rst(rst), .bus(b8b));

   // Issue one op on the empty 32-bit pipe and wait (bounded) for its result.
   task automatic drive_op32(input logic [31:0] a, input logic [31:0] b, input logic cry,
                             input logic sub, output logic [31:0] res, output logic co,
                             output logic ov, output int lat);
      @(negedge clk);
      b32.i_valid = 1'b1; b32.i_num_a = a; b32.i_num_b = b;
      b32.i_cry = cry; b32.i_sub = sub; b32.i_ready = 1'b1;
      @(negedge clk);
      b32.i_valid = 1'b0;
      lat = 1;
      while (!b32.o_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      res = b32.o_res; co = b32.o_cry; ov = b32.o_ovf;
   endtask

   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic cry, input logic sub);
      logic [7:0] be;
      logic [8:0] sum;
      logic       ov;
      be  = sub ? ~b : b;
      sum = {1'b0, a} + {1'b0, be} + {8'd0, cry ^ sub};
      ov  = (a[7] == be[7]) && (sum[7] != a[7]);
      return {ov, sum[8], sum[7:0]};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid: got %b want 0", b32.o_valid); end
      n_vec++; if (b32.o_res !== 32'd0) begin n_err++; $display("FAIL reset_o_res: got %h want 0", b32.o_res); end
      n_vec++; if ({b32.o_cry, b32.o_ovf} !== 2'b00) begin n_err++; $display("FAIL reset_cry_ovf: got %b want 00", {b32.o_cry, b32.o_ovf}); end
      n_vec++; if (b32.o_ready !== 1'b1) begin n_err++; $display("FAIL reset_o_ready: got %b want 1", b32.o_ready); end
      n_vec++; if ({b8a.o_valid, b8b.o_valid} !== 2'b00) begin n_err++; $display("FAIL reset_small_valid: got %b want 00", {b8a.o_valid, b8b.o_valid}); end
   endtask

   task automatic test_add_wrap();
      logic [31:0] r; logic co, ov; int lat;
      drive_op32(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, r, co, ov, lat);
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL wrap_latency: got %0d want 4", lat); end
      n_vec++; if ({ov, co, r} !== {1'b0, 1'b1, 32'h0}) begin n_err++; $display("FAIL wrap_result: got ovf=%b cry=%b res=%h want 0 1 00000000", ov, co, r); end
   endtask

   task automatic test_sub();
      logic [31:0] r; logic co, ov; int lat;
      drive_op32(32'd5, 32'd7, 1'b0, 1'b1, r, co, ov, lat);
      n_vec++; if ({ov, co, r} !== {1'b0, 1'b0, 32'hFFFF_FFFE}) begin n_err++; $display("FAIL sub_5_7: got ovf=%b cry=%b res=%h want 0 0 fffffffe", ov, co, r); end
      drive_op32(32'h8000_0000, 32'd1, 1'b0, 1'b1, r, co, ov, lat);
      n_vec++; if ({ov, co, r} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin n_err++; $display("FAIL sub_min_1: got ovf=%b cry=%b res=%h want 1 1 7fffffff", ov, co, r); end
      drive_op32(32'd10, 32'd3, 1'b1, 1'b1, r, co, ov, lat);
      n_vec++; if ({ov, co, r} !== {1'b0, 1'b1, 32'd6}) begin n_err++; $display("FAIL sub_borrow_in: got ovf=%b cry=%b res=%h want 0 1 00000006", ov, co, r); end
   endtask

   task automatic test_ovf();
      logic [31:0] r; logic co, ov; int lat;
      drive_op32(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, r, co, ov, lat);
      n_vec++; if ({ov, co, r} !== {1'b1, 1'b0, 32'h8000_0000}) begin n_err++; $display("FAIL add_max_1: got ovf=%b cry=%b res=%h want 1 0 80000000", ov, co, r); end
      drive_op32(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, r, co, ov, lat);
      n_vec++; if ({ov, co, r} !== {1'b0, 1'b0, 32'h2143_6588}) begin n_err++; $display("FAIL add_mixed: got ovf=%b cry=%b res=%h want 0 0 21436588", ov, co, r); end
   endtask

   task automatic test_back_to_back();
      int          exp_rdy[8] = '{1, 1, 1, 1, 0, 0, 0, 1};
      int          sent = 0, got = 0, cyc = 0;
      logic [31:0] held = '0;
      logic        held_v = 1'b0;
      while (got < 8 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         b32.i_ready = !(cyc >= 5 && cyc <= 7);
         b32.i_valid = (sent < 8);
         b32.i_num_a = 32'(sent + 1); b32.i_num_b = 32'(sent + 1);
         b32.i_cry = 1'b0; b32.i_sub = 1'b0;
         #1;
         if (cyc <= 8) begin
            n_vec++; if (b32.o_ready !== 1'(exp_rdy[cyc-1])) begin n_err++; $display("FAIL b2b_o_ready cyc%0d: got %b want %0d", cyc, b32.o_ready, exp_rdy[cyc-1]); end
         end
         if (held_v) begin
            n_vec++; if (b32.o_res !== held) begin n_err++; $display("FAIL b2b_hold cyc%0d: got %h want %h", cyc, b32.o_res, held); end
         end
         held_v = b32.o_valid && !b32.i_ready;
         held   = b32.o_res;
         if (b32.o_valid && b32.i_ready) begin
            n_vec++; if (b32.o_res !== 32'(2 * (got + 1))) begin n_err++; $display("FAIL b2b_order #%0d: got %h want %h", got, b32.o_res, 2 * (got + 1)); end
            got++;
         end
         if (b32.i_valid && b32.o_ready) sent++;
      end
      b32.i_valid = 1'b0;
      b32.i_ready = 1'b1;
      n_vec++; if (got !== 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", got); end
   endtask

   task automatic test_mid_reset();
      logic [31:0] r; logic co, ov; int lat; int seen = 0;
      b32.i_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         b32.i_valid = 1'b1; b32.i_num_a = 32'(100 + n); b32.i_num_b = 32'd1;
         b32.i_cry = 1'b0; b32.i_sub = 1'b0;
      end
      @(negedge clk);
      b32.i_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++; if (b32.o_valid !== 1'b0) begin n_err++; $display("FAIL mrst_o_valid: got %b want 0", b32.o_valid); end
      n_vec++; if (b32.o_ready !== 1'b1) begin n_err++; $display("FAIL mrst_o_ready: got %b want 1", b32.o_ready); end
      repeat (8) begin
         @(negedge clk);
         if (b32.o_valid) seen++;
      end
      n_vec++; if (seen !== 0) begin n_err++; $display("FAIL mrst_dropped: got %0d results want 0", seen); end
      drive_op32(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, r, co, ov, lat);
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL mrst_latency: got %0d want 4", lat); end
      n_vec++; if ({ov, co, r} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL mrst_result: got ovf=%b cry=%b res=%h want 0 0 deadbeef", ov, co, r); end
   endtask

   task automatic test_random();
      logic [9:0] qa[$];
      logic [9:0] qb[$];
      logic [9:0] exp;
      for (int cyc = 0; cyc < 430; cyc++) begin
         @(negedge clk);
         if (cyc < 400) begin
            b8a.i_valid = 1'($urandom_range(1)); b8a.i_ready = 1'($urandom_range(1));
            b8b.i_valid = 1'($urandom_range(1)); b8b.i_ready = 1'($urandom_range(1));
         end else begin
            b8a.i_valid = 1'b0; b8a.i_ready = 1'b1;
            b8b.i_valid = 1'b0; b8b.i_ready = 1'b1;
         end
         b8a.i_num_a = 8'($urandom); b8a.i_num_b = 8'($urandom);
         b8a.i_cry = 1'($urandom_range(1)); b8a.i_sub = 1'($urandom_range(1));
         b8b.i_num_a = 8'($urandom); b8b.i_num_b = 8'($urandom);
         b8b.i_cry = 1'($urandom_range(1)); b8b.i_sub = 1'($urandom_range(1));
         #1;
         if (b8a.o_valid && b8a.i_ready) begin
            exp = (qa.size() > 0) ? qa.pop_front() : 10'h3FF;
            n_vec++; if ({b8a.o_ovf, b8a.o_cry, b8a.o_res} !== exp) begin n_err++; $display("FAIL rand_8x1: got %h want %h", {b8a.o_ovf, b8a.o_cry, b8a.o_res}, exp); end
         end
         if (b8b.o_valid && b8b.i_ready) begin
            exp = (qb.size() > 0) ? qb.pop_front() : 10'h3FF;
            n_vec++; if ({b8b.o_ovf, b8b.o_cry, b8b.o_res} !== exp) begin n_err++; $display("FAIL rand_8x8: got %h want %h", {b8b.o_ovf, b8b.o_cry, b8b.o_res}, exp); end
         end
         if (b8a.i_valid && b8a.o_ready) qa.push_back(model8(b8a.i_num_a, b8a.i_num_b, b8a.i_cry, b8a.i_sub));
         if (b8b.i_valid && b8b.o_ready) qb.push_back(model8(b8b.i_num_a, b8b.i_num_b, b8b.i_cry, b8b.i_sub));
      end
      n_vec++; if (qa.size() !== 0) begin n_err++; $display("FAIL rand_8x1_drain: got %0d pending want 0", qa.size()); end
      n_vec++; if (qb.size() !== 0) begin n_err++; $display("FAIL rand_8x8_drain: got %0d pending want 0", qb.size()); end
   endtask

   initial begin
      b32.i_valid = 1'b0; b32.i_ready = 1'b0; b32.i_num_a = '0; b32.i_num_b = '0; b32.i_cry = 1'b0; b32.i_sub = 1'b0;
      b8a.i_valid = 1'b0; b8a.i_ready = 1'b0; b8a.i_num_a = '0; b8a.i_num_b = '0; b8a.i_cry = 1'b0; b8a.i_sub = 1'b0;
      b8b.i_valid = 1'b0; b8b.i_ready = 1'b0; b8b.i_num_a = '0; b8b.i_num_b = '0; b8b.i_cry = 1'b0; b8b.i_sub = 1'b0;
      test_reset();
      test_add_wrap();
      test_sub();
      test_ovf();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
